// File: rtl/pri_sched_pkg.sv
// Shared types and helpers for the priority-aware iSLIP crossbar scheduler.
package pri_sched_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      GRANT,
      ACCEPT,
      DONE
   } state_t;

   // Bits needed to encode `levels` distinct values, never less than one.
   function automatic int pw_of(input int levels);
      return (levels > 1) ? $clog2(levels) : 1;
   endfunction

   localparam int PRI_LEVELS = 64;
   localparam int PRI_W      = pw_of(PRI_LEVELS);

   typedef logic [PRI_W-1:0] pri_t;

endpackage

// File: rtl/rr_pri_arbiter.sv
// Combinational arbiter: highest nonzero priority among eligible requesters,
// ties resolved by the first index at or after ptr (wrapping mod N).
module rr_pri_arbiter
   import pri_sched_pkg::*;
#(
   parameter  int N  = 4,
   parameter  int PW = 6,
   localparam int IW = pw_of(N)
) (
   input  logic [PW-1:0] pri [N],
   input  logic [N-1:0]  eligible,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant
);

   logic [PW-1:0] best_pri;
   logic [IW-1:0] best_idx;
   logic [IW-1:0] idx;
   logic          found;

   always_comb begin
      // NOTE: every output and temporary gets a default first, so no path holds an old value (no latch).
      grant    = '0;
      best_pri = '0;
      best_idx = '0;
      idx      = '0;
      found    = 1'b0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr) + k >= N) ? IW'(int'(ptr) + k - N) : IW'(int'(ptr) + k);
         // Strict '>' keeps the earliest index in rotation order on a tie.
         if (eligible[idx] && (pri[idx] > best_pri)) begin
            best_pri = pri[idx];
            best_idx = idx;
            found    = 1'b1;
         end
      end
      if (found) grant[best_idx] = 1'b1;
   end

endmodule

// File: rtl/pri_slip_scheduler.sv
// Priority-aware iSLIP crossbar scheduler. Define PRI_SCHED_MULTI_ITER_EN for
// ITER grant/accept iterations per round; otherwise a single pass is used.
module pri_slip_scheduler
   import pri_sched_pkg::*;
#(
   parameter  int N    = 4,
   parameter  int P    = 64,
   parameter  int ITER = $clog2(N),
   localparam int PW   = pw_of(P)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [PW-1:0]         pri_req_in [N][N],
   output logic [N-1:0][N-1:0]   decision,
   output logic                  decision_ready
);

   localparam int IW = pw_of(N);
`ifdef PRI_SCHED_MULTI_ITER_EN
   localparam int ITER_EFF = ITER;
`else
   localparam int ITER_EFF = 1;
`endif
   localparam int TW = pw_of(ITER_EFF);

   if (N < 2 || ITER < 1) begin : g_cfg_check
      $error("pri_slip_scheduler: needs N >= 2 and ITER >= 1");
   end

   state_t               state;
   logic [TW-1:0]        iter;
   logic [N-1:0][N-1:0]  match;      // match[i][j]: input i paired with output j
   logic [N-1:0][N-1:0]  grant;      // grant[j][i]: output j granted input i
   logic [N-1:0][N-1:0]  gnt_comb;
   logic [N-1:0][N-1:0]  acc;        // acc[i][j]: input i accepted output j
   logic [N-1:0]         in_matched;
   logic [N-1:0]         out_matched;
   logic [N-1:0]         grant_elig  [N];
   logic [N-1:0]         accept_elig [N];
   logic [PW-1:0]        snap    [N][N];
   logic [PW-1:0]        col_pri [N][N];
   logic [IW-1:0]        grant_ptr  [N];
   logic [IW-1:0]        accept_ptr [N];
   logic                 last_iter;

   function automatic logic [IW-1:0] wrap_inc(input int k);
      return IW'((k + 1) % N);
   endfunction

   always_comb begin
      in_matched  = '0;
      out_matched = '0;
      for (int i = 0; i < N; i++) begin
         in_matched[i] = |match[i];
         for (int j = 0; j < N; j++) begin
            out_matched[j] = out_matched[j] | match[i][j];
            col_pri[j][i]  = snap[i][j];
            accept_elig[i][j] = grant[j][i];
         end
      end
      for (int j = 0; j < N; j++) begin
         grant_elig[j] = out_matched[j] ? '0 : ~in_matched;
      end
      last_iter = (int'(iter) == ITER_EFF - 1);
   end

   for (genvar g = 0; g < N; g++) begin : g_arb
      rr_pri_arbiter #(.N(N), .PW(PW)) u_grant (
         .pri      (col_pri[g]),
         .eligible (grant_elig[g]),
         .ptr      (grant_ptr[g]),
         .grant    (gnt_comb[g])
      );
      rr_pri_arbiter #(.N(N), .PW(PW)) u_accept (
         .pri      (snap[g]),
         .eligible (accept_elig[g]),
         .ptr      (accept_ptr[g]),
         .grant    (acc[g])
      );
   end

   // NOTE: the request snapshot is a plain storage array with no reset; LOAD always writes it before use.
   always_ff @(posedge clk) begin
      if (state == LOAD) snap <= pri_req_in;
   end

   // NOTE: sequential state uses <= so every register in this block sees pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         iter           <= '0;
         match          <= '0;
         grant          <= '0;
         decision       <= '0;
         decision_ready <= 1'b0;
         for (int i = 0; i < N; i++) begin
            grant_ptr[i]  <= '0;
            accept_ptr[i] <= '0;
         end
      end else begin
         decision_ready <= 1'b0;
         case (state)
            IDLE: if (start) state <= LOAD;
            LOAD: begin
               match <= '0;
               iter  <= '0;
               state <= GRANT;
            end
            GRANT: begin
               grant <= gnt_comb;
               state <= ACCEPT;
            end
            ACCEPT: begin
               match <= match | acc;
               // Only first-iteration accepts advance pointers, which keeps them desynchronised.
               if (iter == '0) begin
                  for (int i = 0; i < N; i++) begin
                     for (int j = 0; j < N; j++) begin
                        if (acc[i][j]) begin
                           accept_ptr[i] <= wrap_inc(j);
                           grant_ptr[j]  <= wrap_inc(i);
                        end
                     end
                  end
               end
               if (last_iter) begin
                  decision       <= match | acc;
                  decision_ready <= 1'b1;
                  state          <= DONE;
               end else begin
                  iter  <= iter + 1'b1;
                  state <= GRANT;
               end
            end
            DONE:    state <= start ? LOAD : IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pri_slip_scheduler.sv
// Directed and random bench for pri_slip_scheduler with a behavioural iSLIP reference model.
`timescale 1ns/1ps
module tb_pri_slip_scheduler;

   localparam int N  = 4;
   localparam int P  = 64;
   localparam int PW = 6;
`ifdef PRI_SCHED_MULTI_ITER_EN
   localparam int IT = 2;
`else
   localparam int IT = 1;
`endif
   localparam int LAT = 2 + 2 * IT;

   typedef logic [PW-1:0]        pri_m_t [N][N];
   typedef logic [N-1:0][N-1:0]  dec_t;

   logic   clk = 1'b0;
   logic   reset = 1'b0;
   logic   start = 1'b0;
   pri_m_t pri;
   dec_t   decision;
   logic   decision_ready;

   int     total = 0;
   int     bad   = 0;
   dec_t   sb [$];
   int     m_gptr [N];
   int     m_aptr [N];

   pri_slip_scheduler #(.N(N), .P(P)) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .pri_req_in     (pri),
      .decision       (decision),
      .decision_ready (decision_ready)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference iSLIP round: grant by max priority then rotation from pointer, accept likewise.
   task automatic model_round(input pri_m_t p, output dec_t d);
      logic [N-1:0] im, om;
      int g [N];
      int a [N];
      int best, x;
      d  = '0;
      im = '0;
      om = '0;
      for (int it = 0; it < IT; it++) begin
         for (int j = 0; j < N; j++) begin
            g[j] = -1;
            best = 0;
            if (!om[j]) begin
               for (int k = 0; k < N; k++) begin
                  x = (m_gptr[j] + k) % N;
                  if (!im[x] && int'(p[x][j]) > best) begin best = int'(p[x][j]); g[j] = x; end
               end
            end
         end
         for (int i = 0; i < N; i++) begin
            a[i] = -1;
            best = 0;
            if (!im[i]) begin
               for (int k = 0; k < N; k++) begin
                  x = (m_aptr[i] + k) % N;
                  if (g[x] == i && int'(p[i][x]) > best) begin best = int'(p[i][x]); a[i] = x; end
               end
            end
         end
         for (int i = 0; i < N; i++) begin
            if (a[i] >= 0) begin
               d[i][a[i]] = 1'b1;
               im[i]      = 1'b1;
               om[a[i]]   = 1'b1;
               if (it == 0) begin
                  m_aptr[i]    = (a[i] + 1) % N;
                  m_gptr[a[i]] = (i + 1) % N;
               end
            end
         end
      end
   endtask

   function automatic bit legal(input dec_t d, input pri_m_t p);
      int c;
      for (int i = 0; i < N; i++) if ($countones(d[i]) > 1) return 1'b0;
      for (int j = 0; j < N; j++) begin
         c = 0;
         for (int i = 0; i < N; i++) begin
            c += int'(d[i][j]);
            if (d[i][j] && p[i][j] == '0) return 1'b0;
         end
         if (c > 1) return 1'b0;
      end
      return 1'b1;
   endfunction

   // One start pulse, wait for the ready pulse, compare against the scoreboard head.
   task automatic do_round(input pri_m_t p, input dec_t exp_dec, input string tag);
      int   cyc;
      bit   got;
      dec_t e;
      @(negedge clk);
      pri   = p;
      start = 1'b1;
      sb.push_back(exp_dec);
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < LAT + 4) begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
         if (decision_ready) got = 1'b1;
      end
      check({tag, "_ready"}, 64'(got), 64'(1));
      e = sb.pop_front();
      if (got) begin
         check({tag, "_lat"}, 64'(cyc), 64'(LAT));
         check({tag, "_dec"}, 64'(decision), 64'(e));
         check({tag, "_legal"}, 64'(legal(decision, p)), 64'(1));
      end
      @(negedge clk);
      check({tag, "_pulse"}, 64'(decision_ready), 64'(0));
      check({tag, "_hold"}, 64'(decision), 64'(e));
   endtask

   initial begin
      pri_m_t p_diag, p_pri, p_all7, p_zero, p_rand;
      dec_t   d_id, d_pri, e;
      int     owner_cnt [N];
      int     cyc, last, r;
      bit     saw;

      for (int i = 0; i < N; i++) begin
         m_gptr[i] = 0;
         m_aptr[i] = 0;
         owner_cnt[i] = 0;
         for (int j = 0; j < N; j++) begin
            pri[i][j]    = '0;
            p_zero[i][j] = '0;
            p_all7[i][j] = PW'(7);
            p_diag[i][j] = (i == j) ? PW'(5) : '0;
            p_pri[i][j]  = '0;
         end
      end
      d_id = '0;
      for (int i = 0; i < N; i++) d_id[i][i] = 1'b1;
      p_pri[0][0] = PW'(10); p_pri[1][0] = PW'(10); p_pri[2][0] = PW'(40); p_pri[3][0] = PW'(10);
      p_pri[0][1] = PW'(10); p_pri[3][3] = PW'(20);
      d_pri = '0;
      d_pri[2][0] = 1'b1; d_pri[0][1] = 1'b1; d_pri[3][3] = 1'b1;

      #1;
      check("reset_dec", 64'(decision), 64'(0));
      check("reset_ready", 64'(decision_ready), 64'(0));
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // Diagonal and priority patterns: fixed expected matchings.
      model_round(p_diag, e);
      do_round(p_diag, d_id, "diag");
      model_round(p_pri, e);
      do_round(p_pri, d_pri, "prio");

      // Empty request set still completes rounds.
      for (int k = 0; k < 2; k++) begin
         model_round(p_zero, e);
         do_round(p_zero, '0, "empty");
      end

      // Back-to-back rounds with all-equal priorities and start held high.
      for (int k = 0; k < 8; k++) begin
         model_round(p_all7, e);
         sb.push_back(e);
      end
      @(negedge clk);
      pri   = p_all7;
      start = 1'b1;
      cyc = 0; last = 0; r = 0;
      while (r < 8 && cyc < 8 * LAT + 10) begin
         @(negedge clk);
         cyc++;
         if (decision_ready) begin
            check("b2b_gap", 64'(cyc - last), 64'(LAT));
            last = cyc;
            e = sb.pop_front();
            check("b2b_dec", 64'(decision), 64'(e));
            if (r < 4) begin
               for (int i = 0; i < N; i++) if (decision[i][0]) owner_cnt[i]++;
            end else begin
               saw = 1'b1;
               for (int i = 0; i < N; i++) if ($countones(decision[i]) != 1) saw = 1'b0;
               check("b2b_perm", 64'(saw), 64'(1));
            end
            r++;
            if (r == 8) start = 1'b0;
         end
      end
      start = 1'b0;
      check("b2b_rounds", 64'(r), 64'(8));
      sb.delete();
      for (int i = 0; i < N; i++) check("rr_out0_once", 64'(owner_cnt[i]), 64'(1));
      @(negedge clk);

      // Reset asserted during ACCEPT: no publish, pointers back to zero.
      @(negedge clk);
      pri   = p_diag;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst_dec", 64'(decision), 64'(0));
      check("rst_ready", 64'(decision_ready), 64'(0));
      @(negedge clk);
      reset = 1'b1;
      saw = 1'b0;
      repeat (LAT + 2) begin
         @(negedge clk);
         if (decision_ready) saw = 1'b1;
      end
      check("rst_no_ready", 64'(saw), 64'(0));
      check("rst_dec_hold", 64'(decision), 64'(0));
      for (int i = 0; i < N; i++) begin
         m_gptr[i] = 0;
         m_aptr[i] = 0;
      end
      model_round(p_all7, e);
      do_round(p_all7, e, "rst_ptr");
      model_round(p_diag, e);
      do_round(p_diag, d_id, "rst_diag");

      // Random requests, half the rounds sparse.
      for (int k = 0; k < 1000; k++) begin
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               if ((k % 2 == 1) && ($urandom_range(0, 1) == 0)) p_rand[i][j] = '0;
               else p_rand[i][j] = PW'($urandom_range(0, 63));
            end
         end
         model_round(p_rand, e);
         do_round(p_rand, e, "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
